// File: rtl/tt_alu_accum_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tt_alu_accum_pipe
// Description : Pipelined add / subtract / accumulate / load unit with an
//               optional unsigned saturation mode and status flags. It has
//               two valid/ready stages: S1 holds the computed result and S2
//               is the output register. It accepts one operation per cycle.
// Ports       : clk, rst            - clock, asynchronous active-high reset
//               in_valid/in_ready   - operation handshake (op, a, b)
//               out_valid/out_ready - result handshake (result, carry, zero, sat)
//               acc                 - current accumulator register
// Revision    : 1.0 - initial release
// ============================================================================
module tt_alu_accum_pipe #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             sat,
    output logic [WIDTH-1:0] acc
);

    localparam logic [1:0] c_OP_ADD  = 2'b00;
    localparam logic [1:0] c_OP_SUB  = 2'b01;
    localparam logic [1:0] c_OP_ACC  = 2'b10;
    localparam logic [1:0] c_OP_LOAD = 2'b11;

    logic [WIDTH-1:0] r_acc;
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_result;
    logic             r_s1_carry;
    logic             r_s1_zero;
    logic             r_s1_sat;
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_result;
    logic             r_s2_carry;
    logic             r_s2_zero;
    logic             r_s2_sat;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_add_lhs;
    logic [WIDTH-1:0] w_add_rhs;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_res;
    logic             w_carry;
    logic             w_sat;
    logic             w_zero;

    // Handshake: in_ready looks straight through both stages to out_ready so
    // a full pipeline can still accept while it drains.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv && !rst;
    assign w_accept = in_valid && in_ready;

    // The arithmetic is done in the accept cycle. This lets ACC read the
    // live accumulator, so back-to-back ACC ops chain with no bubble.
    always_comb begin
        w_add_lhs = (op == c_OP_ACC) ? r_acc : a;
        w_add_rhs = (op == c_OP_ACC) ? a : b;
        w_sum     = {1'b0, w_add_lhs} + {1'b0, w_add_rhs};
        w_diff    = {1'b0, a} - {1'b0, b};
        w_res     = '0;
        w_carry   = 1'b0;
        w_sat     = 1'b0;
        case (op)
            c_OP_ADD, c_OP_ACC: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                if (SATURATE && w_carry) begin
                    w_res = '1;
                    w_sat = 1'b1;
                end
            end
            c_OP_SUB: begin
                // The top bit of the widened difference is the unsigned borrow.
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                if (SATURATE && w_carry) begin
                    w_res = '0;
                    w_sat = 1'b1;
                end
            end
            default: begin
                w_res = a;
            end
        endcase
        w_zero = (w_res == '0);
    end

    // The accumulator is written only on an accept edge. A stall therefore
    // can never repeat or delay its update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (w_accept) begin
            if (op == c_OP_ACC) begin
                r_acc <= w_res;
            end else if (op == c_OP_LOAD) begin
                r_acc <= a;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s1_result <= '0;
            r_s1_carry  <= 1'b0;
            r_s1_zero   <= 1'b0;
            r_s1_sat    <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_result <= w_res;
                r_s1_carry  <= w_carry;
                r_s1_zero   <= w_zero;
                r_s1_sat    <= w_sat;
            end
        end
    end

    // zero is registered rather than decoded from result. This keeps it 0
    // out of reset, even though result is also 0 then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid  <= 1'b0;
            r_s2_result <= '0;
            r_s2_carry  <= 1'b0;
            r_s2_zero   <= 1'b0;
            r_s2_sat    <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_result <= r_s1_result;
                r_s2_carry  <= r_s1_carry;
                r_s2_zero   <= r_s1_zero;
                r_s2_sat    <= r_s1_sat;
            end
        end
    end

    assign out_valid = r_s2_valid;
    assign result    = r_s2_result;
    assign carry     = r_s2_carry;
    assign zero      = r_s2_zero;
    assign sat       = r_s2_sat;
    assign acc       = r_acc;

endmodule
`default_nettype wire
